// File: rtl/board_row_server.sv
// Playfield row store for the CPU row interface, with a line-clear shifter and a display read port.
// Optional full-row detector is enabled by defining BOARD_FULL_ROW_DETECT_EN.
module board_row_server #(
  parameter int ROW_W = 32,
  parameter int ROWS  = 31,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index_data_in,
  input  logic [ROW_W-1:0] wr_data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [ROW_W-1:0] rd_data_out,
  output logic             rd_valid,
  input  logic             clr_req,
  input  logic [IDX_W-1:0] clr_index,
  output logic             busy,
  input  logic             disp_req,
  input  logic [IDX_W-1:0] disp_index,
  output logic [ROW_W-1:0] disp_data,
  output logic             disp_valid,
  output logic             full_row_valid,
  output logic [IDX_W-1:0] full_row_index
);

  // state    | meaning
  // ST_IDLE  | serving CPU row reads/writes, accepting clear requests
  // ST_SHIFT | moving rows down one per cycle from ptr to row 0
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  localparam logic [IDX_W-1:0] IDLE_IDX = '1;
  localparam logic [IDX_W-1:0] ROWS_L   = IDX_W'(ROWS);

  state_t           state, next_state;
  logic [ROW_W-1:0] rows [ROWS];
  logic [IDX_W-1:0] ptr;
  logic             clr_go, wr_go, rd_go;

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // A valid clear wins over any CPU access presented in the same cycle.
  always_comb begin
    next_state = state;
    clr_go     = 1'b0;
    wr_go      = 1'b0;
    rd_go      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req && (clr_index < ROWS_L)) begin
          next_state = ST_SHIFT;
          clr_go     = 1'b1;
        end else begin
          wr_go = wr_en && (index_data_in < ROWS_L);
          rd_go = rd_en && (index_data_in != IDLE_IDX);
        end
      end
      ST_SHIFT: begin
        if (ptr == '0) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) rows[i] <= '0;
      ptr         <= '0;
      rd_data_out <= '0;
      rd_valid    <= 1'b0;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go)
        rd_data_out <= (index_data_in < ROWS_L) ? rows[index_data_in] : '0;
      if (clr_go)
        ptr <= clr_index;
      if (state == ST_SHIFT) begin
        if (ptr != '0) begin
          rows[ptr] <= rows[ptr - 1'b1];
          ptr       <= ptr - 1'b1;
        end else begin
          rows[0] <= '0;
        end
      end
      if (wr_go)
        rows[index_data_in] <= wr_data_in;
      // Scan-out reads whatever is registered, even mid-shift.
      disp_valid <= disp_req;
      disp_data  <= (disp_index < ROWS_L) ? rows[disp_index] : '0;
    end
  end

`ifdef BOARD_FULL_ROW_DETECT_EN
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  // Ascending scan so the highest full row is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = IDLE_IDX;
    for (int i = 0; i < ROWS; i++) begin
      if (&rows[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_row_valid <= 1'b0;
      full_row_index <= IDLE_IDX;
    end else begin
      full_row_valid <= hit;
      full_row_index <= hit_idx;
    end
  end
`else
  assign full_row_valid = 1'b0;
  assign full_row_index = IDLE_IDX;
`endif

endmodule

// File: tb/tb_board_row_server.sv
// Scoreboard bench for board_row_server: directed scenarios followed by random traffic.
module tb_board_row_server;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  index_data_in = '0;
  logic [31:0] wr_data_in = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] rd_data_out;
  logic        rd_valid;
  logic        clr_req = 1'b0;
  logic [4:0]  clr_index = '0;
  logic        busy;
  logic        disp_req = 1'b0;
  logic [4:0]  disp_index = '0;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic        full_row_valid;
  logic [4:0]  full_row_index;

  board_row_server dut (
    .clk(clk), .rst(rst), .index_data_in(index_data_in), .wr_data_in(wr_data_in),
    .wr_en(wr_en), .rd_en(rd_en), .rd_data_out(rd_data_out), .rd_valid(rd_valid),
    .clr_req(clr_req), .clr_index(clr_index), .busy(busy), .disp_req(disp_req),
    .disp_index(disp_index), .disp_data(disp_data), .disp_valid(disp_valid),
    .full_row_valid(full_row_valid), .full_row_index(full_row_index)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t rd_q[$];
  exp_t disp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // reference model state
  logic [31:0] m_rows [31];
  int          shift_left = 0;
  int          shift_row = 0;
  int          quiet = 0;
  bit          exp_busy = 1'b0;
  bit          exp_fv = 1'b0, prev_fv = 1'b0;
  logic [4:0]  exp_fi = 5'h1f, prev_fi = 5'h1f;
  bit          full_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic full_of_model(output bit v, output logic [4:0] idx);
    v = 1'b0; idx = 5'h1f;
    for (int i = 0; i < 31; i++)
      if (m_rows[i] == 32'hFFFF_FFFF) begin v = 1'b1; idx = 5'(i); end
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input bit r, input bit w, input bit rd, input logic [4:0] idx,
                      input logic [31:0] d, input bit c, input logic [4:0] ci,
                      input bit dq, input logic [4:0] di);
    bit busy_now;
    bit nv; logic [4:0] ni;
    busy_now = (shift_left > 0);
    exp_busy = busy_now;
    quiet    = busy_now ? 0 : quiet + 1;
    full_chk = (quiet >= 2);
    exp_fv = prev_fv; exp_fi = prev_fi;
    full_of_model(nv, ni);
    prev_fv = nv; prev_fi = ni;

    rst = r; wr_en = w; rd_en = rd; index_data_in = idx; wr_data_in = d;
    clr_req = c; clr_index = ci; disp_req = dq && !busy_now; disp_index = di;

    if (r) begin
      for (int i = 0; i < 31; i++) m_rows[i] = '0;
      shift_left = 0;
      prev_fv = 1'b0; prev_fi = 5'h1f;
      quiet = 0;
    end else begin
      if (dq && !busy_now)
        disp_q.push_back('{cyc + 1, (di < 5'd31) ? m_rows[di] : 32'h0});
      if (busy_now) begin
        shift_left--;
        if (shift_left == 0) begin
          for (int i = shift_row; i > 0; i--) m_rows[i] = m_rows[i-1];
          m_rows[0] = '0;
        end
      end else if (c && ci < 5'd31) begin
        shift_left = int'(ci) + 1;
        shift_row  = int'(ci);
      end else begin
        if (rd && idx != 5'd31)
          rd_q.push_back('{cyc + 1, (idx < 5'd31) ? m_rows[idx] : 32'h0});
        if (w && idx < 5'd31) m_rows[idx] = d;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 5'd31, '0, 0, '0, 0, '0);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    step(0, 1, 0, idx, d, 0, '0, 0, '0);
  endtask

  task automatic rdr(input logic [4:0] idx);
    step(0, 0, 1, idx, '0, 0, '0, 1, idx);
  endtask

  task automatic wait_clear;
    int guard = 0;
    while (shift_left > 0 && guard < 64) begin idle(1); guard++; end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL busy cyc=%0d got=%0b want=%0b", cyc, busy, exp_busy);
      end

      while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL rd_stale cyc=%0d due=%0d", cyc, rd_q[0].due);
        void'(rd_q.pop_front());
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        checks++;
        if (!rd_valid || rd_data_out !== rd_q[0].data) begin
          errors++;
          $display("FAIL rd_data cyc=%0d got=%h valid=%0b want=%h", cyc, rd_data_out, rd_valid, rd_q[0].data);
        end
        void'(rd_q.pop_front());
      end else if (rd_valid) begin
        checks++; errors++;
        $display("FAIL rd_valid_unexpected cyc=%0d got=1 want=0", cyc);
      end

      while (disp_q.size() > 0 && disp_q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL disp_stale cyc=%0d due=%0d", cyc, disp_q[0].due);
        void'(disp_q.pop_front());
      end
      if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
        checks++;
        if (!disp_valid || disp_data !== disp_q[0].data) begin
          errors++;
          $display("FAIL disp_data cyc=%0d got=%h valid=%0b want=%h", cyc, disp_data, disp_valid, disp_q[0].data);
        end
        void'(disp_q.pop_front());
      end else if (disp_valid) begin
        checks++; errors++;
        $display("FAIL disp_valid_unexpected cyc=%0d got=1 want=0", cyc);
      end

`ifdef BOARD_FULL_ROW_DETECT_EN
      if (full_chk) begin
        checks++;
        if (full_row_valid !== exp_fv || full_row_index !== exp_fi) begin
          errors++;
          $display("FAIL full_row cyc=%0d got=%0b/%0d want=%0b/%0d", cyc, full_row_valid, full_row_index, exp_fv, exp_fi);
        end
      end
`else
      checks++;
      if (full_row_valid !== 1'b0 || full_row_index !== 5'h1f) begin
        errors++;
        $display("FAIL full_row_tied cyc=%0d got=%0b/%0d want=0/31", cyc, full_row_valid, full_row_index);
      end
`endif
    end
  end

  initial begin
    logic [4:0]  ri, rc, rdi;
    logic [31:0] rdat;
    bit rw, rr, rcq, rdq;

    for (int i = 0; i < 31; i++) m_rows[i] = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 5'd31, '0, 0, '0, 0, '0);
    step(1, 0, 0, 5'd31, '0, 0, '0, 0, '0);
    mon_en = 1'b1;
    checks++;
    if (rd_data_out !== 32'h0 || disp_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got=%h/%h want=0/0", rd_data_out, disp_data);
    end

    // basic read/write and idle index
    rdr(5'd5);
    wr(5'd3, 32'hDEADBEEF);
    rdr(5'd3);
    rdr(5'd31);
    idle(2);

    // read-before-write on the same index
    wr(5'd7, 32'h1);
    step(0, 1, 1, 5'd7, 32'h2, 0, '0, 0, '0);
    rdr(5'd7);
    idle(1);

    // line clear of row 3 with a write attempted while busy
    for (int i = 0; i < 5; i++) wr(5'(i), 32'(i + 1));
    step(0, 1, 1, 5'd1, 32'h77, 1, 5'd3, 0, '0);
    wr(5'd2, 32'hAAAA_5555);
    step(0, 0, 0, 5'd31, '0, 1, 5'd0, 0, '0);
    wait_clear;
    for (int i = 0; i < 5; i++) rdr(5'(i));
    idle(1);

    // out-of-range clear is ignored
    step(0, 0, 0, 5'd31, '0, 1, 5'd31, 0, '0);
    idle(1);

    // reset during the second shift cycle
    step(0, 0, 0, 5'd31, '0, 1, 5'd3, 0, '0);
    idle(1);
    step(1, 0, 0, 5'd31, '0, 0, '0, 0, '0);
    for (int i = 0; i < 5; i++) rdr(5'(i));
    idle(1);

    // full-row detection across a clear
    wr(5'd10, 32'hFFFF_FFFF);
    wr(5'd20, 32'hFFFF_FFFF);
    idle(3);
    step(0, 0, 0, 5'd31, '0, 1, 5'd20, 0, '0);
    wait_clear;
    idle(3);
    rdr(5'd11);
    rdr(5'd20);
    idle(1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      ri   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      rdat = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      rw   = ($urandom_range(0, 2) == 0);
      rr   = ($urandom_range(0, 2) == 0);
      rcq  = ($urandom_range(0, 39) == 0);
      rc   = 5'($urandom_range(0, 31));
      rdq  = ($urandom_range(0, 1) == 0);
      rdi  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 499) == 0)
        step(1, rw, rr, ri, rdat, rcq, rc, 0, rdi);
      else
        step(0, rw, rr, ri, rdat, rcq, rc, rdq, rdi);
    end
    wait_clear;
    idle(3);

    checks++;
    if (rd_q.size() != 0 || disp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got=%0d/%0d want=0/0", rd_q.size(), disp_q.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
